exe_stage: RTL

Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs (control bits, operands, sign-extended immediate, destination address), computes the ALU result, and registers everything into the EX/MEM pipeline register for the memory stage. It also drives a same-cycle forwarding port for the ID-stage bypass muxes. It supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/alu.sv | 40 ++++
 rtl/exe_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, default widths, register-zero constant.
package mips_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bits carried in the EX/MEM slot
  typedef struct packed {
    logic valid;
    logic wreg;
    logic m2reg;
    logic wmem;
  } mctl_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; overflow reports signed overflow of ADD/SUB only.
module alu
  import mips_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    aluc,
  output logic [DW-1:0] result,
  output logic          overflow
);

  logic [4:0] sh;
  assign sh = a[4:0];

  // Operation select and signed-overflow detection
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (aluc)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = b << sh;
      ALU_SRL: result = b >> sh;
      ALU_SRA: result = DW'($signed(b) >>> sh);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: operand muxes, ALU, EX/MEM register and EX forwarding port.
// Optional feature macro: EXE_OVF_TRAP_EN (ADD/SUB signed-overflow trap with sticky ovf).
module exe_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          e_valid,
  input  logic          EWREG,
  input  logic          EM2REG,
  input  logic          EWMEM,
  input  logic          EALUIMM,
  input  logic          ESHIFT,
  input  logic [2:0]    EALUC,
  input  logic [DW-1:0] EXE_SrcA,
  input  logic [DW-1:0] EXE_SrcB,
  input  logic [DW-1:0] SA,
  input  logic [AW-1:0] EXE_REG_ADDR,
  output logic          m_valid,
  output logic          MWREG,
  output logic          MM2REG,
  output logic          MWMEM,
  output logic [DW-1:0] MALU,
  output logic [DW-1:0] MSTORE,
  output logic [AW-1:0] MREG_ADDR,
  output logic          fwd_we,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data
`ifdef EXE_OVF_TRAP_EN
  ,
  output logic          ovf
`endif
);

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          alu_ovf;
  logic          we_eff;
  logic          trap;
  logic          load_en;
  logic          bubble;
  mctl_t         ctl_next;
  mctl_t         ctl_q;

  // Operand selection: shift amount from immediate, immediate as B
  always_comb begin
    op_a = EXE_SrcA;
    op_b = EXE_SrcB;
    if (ESHIFT)  op_a = DW'(SA[10:6]);
    if (EALUIMM) op_b = SA;
  end

  alu #(.DW(DW)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .aluc     (EALUC),
    .result   (alu_res),
    .overflow (alu_ovf)
  );

`ifdef EXE_OVF_TRAP_EN
  assign trap = e_valid & alu_ovf;
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
  assign trap       = 1'b0;
`endif

  // Effective GPR write: real instruction, not $0, not trapped
  assign we_eff = EWREG & e_valid & (EXE_REG_ADDR != AW'(REG_ZERO)) & ~trap;

  assign fwd_we   = we_eff & ~EM2REG;
  assign fwd_addr = EXE_REG_ADDR;
  assign fwd_data = alu_res;

  // Next control word for the EX/MEM slot
  always_comb begin
    ctl_next       = '0;
    ctl_next.valid = e_valid;
    ctl_next.wreg  = we_eff;
    ctl_next.m2reg = EM2REG & e_valid;
    ctl_next.wmem  = EWMEM & e_valid;
  end

  // flush wins over stall; an invalid slot without stall is also a bubble
  assign bubble  = flush | (~stall & ~e_valid);
  assign load_en = ~stall & ~flush & e_valid;

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q     <= '0;
      MALU      <= '0;
      MSTORE    <= '0;
      MREG_ADDR <= '0;
    end else if (bubble) begin
      ctl_q     <= '0;
      MALU      <= '0;
      MSTORE    <= '0;
      MREG_ADDR <= '0;
    end else if (load_en) begin
      ctl_q     <= ctl_next;
      MALU      <= alu_res;
      MSTORE    <= EXE_SrcB;
      MREG_ADDR <= EXE_REG_ADDR;
    end
  end

  assign m_valid = ctl_q.valid;
  assign MWREG   = ctl_q.wreg;
  assign MM2REG  = ctl_q.m2reg;
  assign MWMEM   = ctl_q.wmem;

`ifdef EXE_OVF_TRAP_EN
  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  ovf <= 1'b0;
    else if (load_en && trap)  ovf <= 1'b1;
  end
`endif

endmodule
